fp_mult_arbiter: RTL and testbench
==================================

FP_MULT_ARBITER -- requirements
Module: fp_mult_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in IEEE-754 single format.
REQ-002 Parameter NREQ, default 4, number of requesters; legal range 2..4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NREQ  bit i: requester i has an operand pair pending.
REQ-006 req_a  input  NREQ*WIDTH  operand A of requester i at bits [i*WIDTH +: WIDTH].
REQ-007 req_b  input  NREQ*WIDTH  operand B of requester i, same packing.
REQ-008 req_ready  output  NREQ  one-hot (or zero) accept strobe to requester i.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_id  output  2  index of requester owning the result.
REQ-011 rsp_result  output  WIDTH  product A*B.
REQ-012 rsp_ready  input  1  consumer accepts result.
REQ-013 op_count  output  16  count of completed responses.

Function
REQ-014 Block SHALL contain exactly one instance of the combinational FloatingMultiplication unit (ports A, B, result), shared by all requesters.
REQ-015 FSM SHALL have states IDLE, EXEC, RESP.
REQ-016 IDLE: if any req_valid bit is set, grant the first set bit searching upward (with wrap) from rr_ptr; otherwise remain in IDLE.
REQ-017 In IDLE with a grant, req_ready[g] SHALL be 1 combinationally for the granted index only; all other bits 0.
REQ-018 req_ready SHALL be all-zero in EXEC and RESP and in IDLE with no valid request.
REQ-019 On grant edge: capture req_a[g], req_b[g] into operand registers, g into id register; next state EXEC.
REQ-020 EXEC: multiplier driven from operand registers; its output registered into result register on the edge; next state RESP.
REQ-021 RESP: rsp_valid=1; rsp_id and rsp_result held stable until rsp_ready=1 is sampled.
REQ-022 RESP with rsp_ready=1: next state IDLE, rr_ptr := (id+1) mod NREQ, op_count increments by 1.
REQ-023 RESP with rsp_ready=0: remain in RESP, no state change.
REQ-024 Latency: grant at edge t, rsp_valid high from cycle after edge t+1; minimum 3 cycles per operation (IDLE, EXEC, RESP).
REQ-025 op_count SHALL wrap 0xFFFF -> 0x0000.
REQ-026 req_valid changes while in EXEC/RESP SHALL have no effect on the operation in flight.
REQ-027 rsp_result SHALL equal the multiplier output bit-exactly; no rounding or special-case handling in this block.
REQ-028 A requester that deasserts req_valid before grant SHALL not be served.

Reset
REQ-029 rst=1 at an edge: state := IDLE, rr_ptr := 0, op_count := 0, operand/result/id registers := 0.
REQ-030 Outputs after reset: rsp_valid=0, rsp_id=0, rsp_result=0, op_count=0, req_ready=0 unless IDLE grant applies.
REQ-031 rst during EXEC or RESP SHALL discard the operation: no response, op_count not incremented.
REQ-032 rst has priority over every other event in the same cycle.

Verification
REQ-033 Single request: req_valid=0001, A=0x40600000, B=0x40900000, rsp_ready=1 -> req_ready=0001 in grant cycle, rsp_valid 2 cycles later, rsp_result=0x417C0000, rsp_id=0, op_count=1.
REQ-034 All four valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0; one response per 3 cycles; rsp_id follows same order.
REQ-035 Backpressure: req 2 with A=0x40000000, B=0xC0400000, rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_result=0xC0C00000, rsp_id=2 stable, req_ready all-zero; release -> IDLE next, op_count+1.
REQ-036 Operand change after grant: req 1 A=0x3FC00000, B=0x3FC00000, change req_a/req_b in EXEC -> rsp_result=0x40100000.
REQ-037 Reset mid-op: rst pulsed during EXEC -> rsp_valid stays 0, op_count=0, next grant searches from index 0.
REQ-038 Wrap: preload via 65535 responses (or forced) -> next response yields op_count=0x0000.

Source files
------------

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: round-robin arbiter that lends one combinational FP32
// multiplier to up to four requesters, one operation at a time.
//
// Handshake contract:
//   - Request side: req_ready[g] is a combinational, one-hot accept strobe.
//     It is raised only in IDLE, and only for the requester picked by the
//     round-robin search. The operands are taken on the rising edge where
//     req_valid[g] && req_ready[g] holds.
//   - Response side: rsp_valid stays high, and rsp_id/rsp_result stay stable,
//     until a rising edge samples rsp_ready=1. The response is consumed on
//     that edge.
//
// WIDTH must stay 32, because the shared multiplier is IEEE-754 single precision.

// FloatingMultiplication: combinational IEEE-754 single multiply.
// Rounding is round-to-nearest-even. Denormal inputs and underflowing results
// are flushed to signed zero. Overflow gives signed infinity, and any invalid
// operation gives the canonical quiet NaN.
module FloatingMultiplication (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result
);
  logic              w_sign;
  logic [7:0]        w_ea;
  logic [7:0]        w_eb;
  logic [23:0]       w_ma;
  logic [23:0]       w_mb;
  logic [47:0]       w_prod;
  logic [22:0]       w_frac;
  logic              w_guard;
  logic              w_sticky;
  logic              w_round;
  logic [23:0]       w_frac_r;
  logic signed [9:0] w_exp;
  logic signed [9:0] w_exp_r;
  logic              w_a_zero;
  logic              w_b_zero;
  logic              w_a_inf;
  logic              w_b_inf;
  logic              w_a_nan;
  logic              w_b_nan;

  // Normalise the 48-bit significand product, round to nearest even, then
  // resolve the special operands and any exponent range overflow.
  always_comb begin
    w_sign   = A[31] ^ B[31];
    w_ea     = A[30:23];
    w_eb     = B[30:23];
    w_ma     = {1'b1, A[22:0]};
    w_mb     = {1'b1, B[22:0]};
    w_prod   = 48'(w_ma) * 48'(w_mb);
    w_a_zero = (w_ea == 8'h00);
    w_b_zero = (w_eb == 8'h00);
    w_a_inf  = (w_ea == 8'hFF) && (A[22:0] == 23'd0);
    w_b_inf  = (w_eb == 8'hFF) && (B[22:0] == 23'd0);
    w_a_nan  = (w_ea == 8'hFF) && (A[22:0] != 23'd0);
    w_b_nan  = (w_eb == 8'hFF) && (B[22:0] != 23'd0);
    if (w_prod[47]) begin
      w_frac   = w_prod[46:24];
      w_guard  = w_prod[23];
      w_sticky = |w_prod[22:0];
      w_exp    = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd126;
    end else begin
      w_frac   = w_prod[45:23];
      w_guard  = w_prod[22];
      w_sticky = |w_prod[21:0];
      w_exp    = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;
    end
    w_round  = w_guard & (w_sticky | w_frac[0]);
    w_frac_r = {1'b0, w_frac} + {23'd0, w_round};
    // A rounding carry out of the fraction means the significand became 2.0.
    w_exp_r  = w_frac_r[23] ? (w_exp + 10'sd1) : w_exp;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
      result = 32'h7FC0_0000;
    else if (w_a_inf || w_b_inf)
      result = {w_sign, 8'hFF, 23'd0};
    else if (w_a_zero || w_b_zero)
      result = {w_sign, 31'd0};
    else if (w_exp_r >= 10'sd255)
      result = {w_sign, 8'hFF, 23'd0};
    else if (w_exp_r <= 10'sd0)
      result = {w_sign, 31'd0};
    else
      result = {w_sign, w_exp_r[7:0], w_frac_r[22:0]};
  end
endmodule

module fp_mult_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  input  logic                  rsp_ready,
  output logic [15:0]           op_count,
  output logic [1:0]            dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [1:0]        r_rr_ptr;
  logic [1:0]        r_id;
  logic [WIDTH-1:0]  r_op_a;
  logic [WIDTH-1:0]  r_op_b;
  logic [WIDTH-1:0]  r_result;
  logic              r_rsp_valid;
  logic [15:0]       r_op_count;

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic              w_grant_any;
  logic [1:0]        w_offset;
  logic [2:0]        w_sum;
  logic [2:0]        w_wrap;
  logic [1:0]        w_grant_idx;
  logic [1:0]        w_next_ptr;
  logic [WIDTH-1:0]  w_mul_result;

  // Round-robin search: rotate the requests so rr_ptr lands at bit 0, take
  // the lowest set bit, then map that offset back to a requester index.
  always_comb begin
    w_dbl       = {req_valid, req_valid} >> r_rr_ptr;
    w_rot       = w_dbl[NREQ-1:0];
    w_grant_any = |w_rot;
    w_offset    = 2'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_offset = k[1:0];
    end
    w_sum       = {1'b0, r_rr_ptr} + {1'b0, w_offset};
    w_wrap      = w_sum - 3'(NREQ);
    w_grant_idx = (w_sum >= 3'(NREQ)) ? w_wrap[1:0] : w_sum[1:0];
    w_next_ptr  = (r_id == 2'(NREQ - 1)) ? 2'd0 : (r_id + 2'd1);
  end

  // Accept strobe: only in IDLE, and only to the chosen requester.
  always_comb begin
    req_ready = '0;
    if ((r_state == S_IDLE) && w_grant_any)
      req_ready = {{(NREQ-1){1'b0}}, 1'b1} << w_grant_idx;
  end

  // The single shared multiplier always works from the captured operands, so
  // requester activity after the grant cannot disturb the operation in flight.
  FloatingMultiplication u_fmul (
    .A      (r_op_a),
    .B      (r_op_b),
    .result (w_mul_result)
  );

  // Operation sequencer: the IDLE grant captures the operands, EXEC registers
  // the product, and RESP holds the response until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= 2'd0;
      r_id        <= 2'd0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_result    <= '0;
      r_rsp_valid <= 1'b0;
      r_op_count  <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_op_a  <= req_a[w_grant_idx*WIDTH +: WIDTH];
            r_op_b  <= req_b[w_grant_idx*WIDTH +: WIDTH];
            r_id    <= w_grant_idx;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_result    <= w_mul_result;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rr_ptr    <= w_next_ptr;
            r_op_count  <= r_op_count + 16'd1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign op_count   = r_op_count;
  assign dbg_state  = r_state;
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb_fp_mult_arbiter: directed and randomized checks of the shared-multiplier
// arbiter against a transaction-level reference model.
`timescale 1ns/1ps
module tb_fp_mult_arbiter;
  localparam int WIDTH = 32;
  localparam int NREQ  = 4;

  // ---------------- clock / reset / DUT ----------------
  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [1:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_ready;
  logic [15:0]           op_count;
  logic [1:0]            dbg_state;

  always #5 clk = ~clk;

  fp_mult_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ready  (rsp_ready),
    .op_count   (op_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          m_ptr;
  bit          m_busy;
  int          m_age;
  int          m_count;
  logic [33:0] exp_q[$];
  int          got_ids[$];
  int          last_grant;
  int          cnt_before;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference product: widen both singles to doubles exactly, multiply in
  // real arithmetic (a 48-bit product is exact in a double), then round the
  // double to single with round-to-nearest-even. Operands are kept in a range
  // where the result is always a normal number.
  function automatic logic [63:0] sp_to_dp(input logic [31:0] s);
    logic [10:0] e;
    e = 11'(s[30:23]) + 11'd896;
    return {s[31], e, s[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b);
    real         ra;
    real         rb;
    real         rp;
    logic [63:0] d;
    logic [23:0] k1;
    logic [28:0] rest;
    int          e;
    ra   = $bitstoreal(sp_to_dp(a));
    rb   = $bitstoreal(sp_to_dp(b));
    rp   = ra * rb;
    d    = $realtobits(rp);
    e    = int'(d[62:52]) - 896;
    k1   = {1'b0, d[51:29]};
    rest = d[28:0];
    if ((rest > 29'h1000_0000) || ((rest == 29'h1000_0000) && k1[0])) k1 = k1 + 24'd1;
    if (k1[23]) e = e + 1;
    return {d[63], e[7:0], k1[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] f;
    logic        s;
    s = 1'($urandom_range(1, 0));
    e = 8'($urandom_range(154, 100));
    f = 23'($urandom);
    return {s, e, f};
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_busy  = 1'b0;
    m_age   = 0;
    m_count = 0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  // One clock cycle: check the outputs against the model for the current
  // inputs, advance the model across the edge, then check op_count.
  task automatic step();
    int              g;
    logic [NREQ-1:0] exp_ready;
    logic [33:0]     head;
    #1;
    g = -1;
    if (!m_busy) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if ((g < 0) && req_valid[idx]) g = idx;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_busy && (m_age >= 2)));
    if (m_busy && (m_age >= 2) && (exp_q.size() > 0)) begin
      head = exp_q[0];
      chk("rsp_id", 64'(rsp_id), 64'(head[33:32]));
      chk("rsp_result", 64'(rsp_result), 64'(head[31:0]));
    end
    last_grant = -1;
    if (rst) begin
      model_reset();
    end else if (g >= 0) begin
      exp_q.push_back({2'(g), fp_ref(req_a[g*WIDTH +: WIDTH], req_b[g*WIDTH +: WIDTH])});
      m_busy     = 1'b1;
      m_age      = 1;
      last_grant = g;
    end else if (m_busy) begin
      if (m_age < 2) begin
        m_age++;
      end else if (rsp_ready) begin
        head = exp_q.pop_front();
        got_ids.push_back(int'(rsp_id));
        m_ptr   = (int'(head[33:32]) + 1) % NREQ;
        m_busy  = 1'b0;
        m_count = (m_count + 1) % 65536;
      end
    end
    @(posedge clk);
    #1;
    chk("op_count", 64'(op_count), 64'(m_count));
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
    chk("reset_rsp_result", 64'(rsp_result), 64'd0);
    chk("reset_op_count", 64'(op_count), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;

    // Single request on requester 0: 3.5 * 4.5 = 15.75
    set_req(0, 32'h4060_0000, 32'h4090_0000);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    chk("single_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    step();
    chk("single_valid", 64'(rsp_valid), 64'd1);
    chk("single_result", 64'(rsp_result), 64'h417C_0000);
    chk("single_id", 64'(rsp_id), 64'd0);
    step();
    chk("single_count", 64'(op_count), 64'd1);

    // Four requesters valid continuously: fair rotation from index 0.
    reset_dut();
    for (int i = 0; i < NREQ; i++) set_req(i, rand_fp(), rand_fp());
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    got_ids.delete();
    repeat (15) step();
    req_valid = '0;
    chk("rr_num_rsp", 64'(got_ids.size()), 64'd5);
    if (got_ids.size() == 5) begin
      chk("rr_id0", 64'(got_ids[0]), 64'd0);
      chk("rr_id1", 64'(got_ids[1]), 64'd1);
      chk("rr_id2", 64'(got_ids[2]), 64'd2);
      chk("rr_id3", 64'(got_ids[3]), 64'd3);
      chk("rr_id4", 64'(got_ids[4]), 64'd0);
    end

    // Backpressure on requester 2: 2.0 * -3.0 = -6.0, others kept pending.
    set_req(2, 32'h4000_0000, 32'hC040_0000);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    step();
    req_valid = 4'b1011;
    step();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_result", 64'(rsp_result), 64'hC0C0_0000);
      chk("bp_id", 64'(rsp_id), 64'd2);
      chk("bp_ready_zero", 64'(req_ready), 64'd0);
      step();
    end
    req_valid  = '0;
    rsp_ready  = 1'b1;
    cnt_before = m_count;
    step();
    chk("bp_release_valid", 64'(rsp_valid), 64'd0);
    chk("bp_release_count", 64'(op_count), 64'((cnt_before + 1) % 65536));

    // Operands change while the operation is executing: 1.5 * 1.5 = 2.25
    set_req(1, 32'h3FC0_0000, 32'h3FC0_0000);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    set_req(1, rand_fp(), rand_fp());
    step();
    chk("opchg_result", 64'(rsp_result), 64'h4010_0000);
    step();

    // Reset during EXEC: the operation is dropped and the search restarts at 0.
    set_req(0, rand_fp(), rand_fp());
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_valid", 64'(rsp_valid), 64'd0);
    chk("rstmid_count", 64'(op_count), 64'd0);
    chk("rstmid_result", 64'(rsp_result), 64'd0);
    set_req(1, rand_fp(), rand_fp());
    set_req(3, rand_fp(), rand_fp());
    req_valid = 4'b1010;
    #1;
    chk("rstmid_grant", 64'(req_ready), 64'b0010);
    step();
    req_valid = 4'b1000;
    step();
    step();
    req_valid = '0;
    repeat (4) step();

    // Counter wrap: preload the count to 0xFFFF, then complete one operation.
    step();
    force dut.r_op_count = 16'hFFFF;
    #1;
    release dut.r_op_count;
    m_count = 65535;
    chk("wrap_pre", 64'(op_count), 64'hFFFF);
    set_req(3, rand_fp(), rand_fp());
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    step();
    step();
    chk("wrap_zero", 64'(op_count), 64'd0);

    // Randomized traffic: arrivals, withdrawals, backpressure and rare resets.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(2, 0) == 0) begin
            set_req(i, rand_fp(), rand_fp());
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(19, 0) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(3, 0) != 0);
      rst       = ($urandom_range(149, 0) == 0);
      step();
      if (last_grant >= 0) req_valid[last_grant] = 1'b0;
    end
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
